// File: rtl/jacobi_pkg.sv
// Shared types, constants and fixed-point helpers for the Jacobi 5-point solver.
package jacobi_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle  = 3'd0;
   localparam state_t StLoad  = 3'd1;
   localparam state_t StSweep = 3'd2;
   localparam state_t StCheck = 3'd3;
   localparam state_t StDrain = 3'd4;

   // 1.0 in the default Q8.24 format
   localparam logic [31:0] FIX_ONE = 32'h0100_0000;

   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int unsigned w);
      logic [63:0] hi;
      hi = (64'd1 << w) - 64'd1;
      return (v > hi) ? hi : v;
   endfunction

   function automatic logic is_boundary(input int unsigned row, input int unsigned col,
                                        input int unsigned last);
      return (row == 0) || (row == last) || (col == 0) || (col == last);
   endfunction

endpackage

// File: rtl/jacobi_stencil_pe.sv
// Combinational 5-point stencil update for one cell: new value and its absolute change.
module jacobi_stencil_pe
   import jacobi_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] north_i,
   input  logic signed [DATA_W-1:0] south_i,
   input  logic signed [DATA_W-1:0] east_i,
   input  logic signed [DATA_W-1:0] west_i,
   input  logic signed [DATA_W-1:0] center_i,
   input  logic signed [DATA_W-1:0] h2f_i,
   input  logic                     boundary_i,
   output logic signed [DATA_W-1:0] new_o,
   output logic        [DATA_W-1:0] diff_o
);

   logic signed [DATA_W+2:0] sum;
   logic signed [63:0]       sum64;
   logic signed [DATA_W-1:0] stencil;
   logic        [DATA_W:0]   delta;
   logic        [DATA_W:0]   mag;

   always_comb begin
      // Five DATA_W operands need three guard bits to never overflow
      sum = {{3{north_i[DATA_W-1]}}, north_i} + {{3{south_i[DATA_W-1]}}, south_i}
          + {{3{east_i[DATA_W-1]}}, east_i} + {{3{west_i[DATA_W-1]}}, west_i}
          + {{3{h2f_i[DATA_W-1]}}, h2f_i};
      sum64   = {{(61 - DATA_W){sum[DATA_W+2]}}, sum};
      stencil = DATA_W'(sat_signed(sum64 >>> 2, DATA_W));
      delta   = {stencil[DATA_W-1], stencil} - {center_i[DATA_W-1], center_i};
      mag     = delta[DATA_W] ? -delta : delta;
      new_o   = boundary_i ? center_i : stencil;
      diff_o  = boundary_i ? '0
                           : DATA_W'(sat_unsigned({{(63 - DATA_W){1'b0}}, mag}, DATA_W));
   end

endmodule

// File: rtl/jacobi_5pt_solver.sv
// Jacobi 5-point solver: load a grid, sweep it between two ping-pong banks until the largest
// cell change is within tolerance or the sweep limit is hit, then stream the newest bank out.
module jacobi_5pt_solver
   import jacobi_pkg::*;
#(
   parameter int unsigned M      = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FRAC_W = 24,
   parameter int unsigned ITER_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] tol,
   input  logic [ITER_W-1:0] max_iter,
   input  logic [DATA_W-1:0] h2f,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [ITER_W-1:0] iter_count
);

   localparam int unsigned N     = M + 2;
   localparam int unsigned DEPTH = N * N;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned RW    = $clog2(N);
   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   if (FRAC_W >= DATA_W) begin : g_bad_frac
      $error("FRAC_W must leave at least a sign bit in DATA_W");
   end

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [RW-1:0]     row_q, row_d;
   logic [RW-1:0]     col_q, col_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [ITER_W-1:0] max_iter_q, max_iter_d;
   logic [DATA_W-1:0] tol_q, tol_d;
   logic [DATA_W-1:0] h2f_q, h2f_d;
   logic [DATA_W-1:0] max_diff_q, max_diff_d;
   logic              converged_q, converged_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] mem_q [2][DEPTH];
   logic              mem_we, mem_wsel;
   logic [DATA_W-1:0] mem_wdata;

   logic              adv, last, boundary;
   logic [AW-1:0]     addr_n, addr_s, addr_e, addr_w;
   logic [DATA_W-1:0] rd_c, rd_n, rd_s, rd_e, rd_w;
   logic [DATA_W-1:0] pe_new, pe_diff;

   // Boundary cells never use neighbours, so their indices fall back to the cell itself
   always_comb begin
      boundary = is_boundary(32'(row_q), 32'(col_q), N - 1);
      addr_n   = boundary ? addr_q : addr_q - AW'(N);
      addr_s   = boundary ? addr_q : addr_q + AW'(N);
      addr_e   = boundary ? addr_q : addr_q + AW'(1);
      addr_w   = boundary ? addr_q : addr_q - AW'(1);
   end

   assign rd_c = mem_q[sel_q][addr_q];
   assign rd_n = mem_q[sel_q][addr_n];
   assign rd_s = mem_q[sel_q][addr_s];
   assign rd_e = mem_q[sel_q][addr_e];
   assign rd_w = mem_q[sel_q][addr_w];
   assign last = (addr_q == LastAddr);

   jacobi_stencil_pe #(
      .DATA_W(DATA_W)
   ) u_pe (
      .north_i   (rd_n),
      .south_i   (rd_s),
      .east_i    (rd_e),
      .west_i    (rd_w),
      .center_i  (rd_c),
      .h2f_i     (h2f_q),
      .boundary_i(boundary),
      .new_o     (pe_new),
      .diff_o    (pe_diff)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      row_d       = row_q;
      col_d       = col_q;
      iter_d      = iter_q;
      max_iter_d  = max_iter_q;
      tol_d       = tol_q;
      h2f_d       = h2f_q;
      max_diff_d  = max_diff_q;
      converged_d = converged_q;
      done_d      = 1'b0;
      adv         = 1'b0;
      mem_we      = 1'b0;
      mem_wsel    = sel_q;
      mem_wdata   = in_data;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StLoad;
               tol_d       = tol;
               max_iter_d  = (max_iter == '0) ? ITER_W'(1) : max_iter;
               h2f_d       = h2f;
               iter_d      = '0;
               converged_d = 1'b0;
               max_diff_d  = '0;
               addr_d      = '0;
               row_d       = '0;
               col_d       = '0;
            end
         end
         StLoad: begin
            if (in_valid) begin
               mem_we = 1'b1;
               adv    = 1'b1;
               if (last) state_d = StSweep;
            end
         end
         StSweep: begin
            mem_we    = 1'b1;
            mem_wsel  = ~sel_q;
            mem_wdata = pe_new;
            adv       = 1'b1;
            if (pe_diff > max_diff_q) max_diff_d = pe_diff;
            if (last) state_d = StCheck;
         end
         StCheck: begin
            sel_d  = ~sel_q;
            iter_d = iter_q + ITER_W'(1);
            if (max_diff_q <= tol_q) begin
               converged_d = 1'b1;
               state_d     = StDrain;
            end else if ((iter_q + ITER_W'(1)) == max_iter_q) begin
               converged_d = 1'b0;
               state_d     = StDrain;
            end else begin
               max_diff_d = '0;
               state_d    = StSweep;
            end
         end
         StDrain: begin
            if (out_ready) begin
               adv = 1'b1;
               if (last) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
         state_d     = StIdle;
         sel_d       = sel_q;
         iter_d      = iter_q;
         converged_d = 1'b0;
         done_d      = 1'b0;
         adv         = 1'b0;
         mem_we      = 1'b0;
      end

      // Row/column counters track the linear address so no divider is needed
      if (adv) begin
         if (last) begin
            addr_d = '0;
            row_d  = '0;
            col_d  = '0;
         end else begin
            addr_d = addr_q + AW'(1);
            if (col_q == RW'(N - 1)) begin
               col_d = '0;
               row_d = row_q + RW'(1);
            end else begin
               col_d = col_q + RW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         iter_q      <= '0;
         max_iter_q  <= '0;
         tol_q       <= '0;
         h2f_q       <= '0;
         max_diff_q  <= '0;
         converged_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         row_q       <= row_d;
         col_q       <= col_d;
         iter_q      <= iter_d;
         max_iter_q  <= max_iter_d;
         tol_q       <= tol_d;
         h2f_q       <= h2f_d;
         max_diff_q  <= max_diff_d;
         converged_q <= converged_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wsel][addr_q] <= mem_wdata;
   end

   assign in_ready   = (state_q == StLoad);
   assign out_valid  = (state_q == StDrain);
   assign out_data   = out_valid ? rd_c : '0;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign converged  = converged_q;
   assign iter_count = iter_q;

endmodule

// File: doc/jacobi_5pt_solver.md
Name: jacobi_5pt_solver

Overview:
Parametrised iterative Jacobi 5-point stencil solver for Laplace/Poisson problems on an (M+2)x(M+2) grid with a fixed boundary. It works in signed fixed-point and uses ping-pong grid banks, so no bulk copy is needed between sweeps. Convergence tolerance and iteration limit are runtime inputs, and a constant source term is supported. Grid load and result readout are ready/valid streams, and the output side honours backpressure.

Parameters:
M, 4, interior grid dimension; full grid is N=(M+2), DEPTH=N*N cells
DATA_W, 32, sample width, signed two's complement
FRAC_W, 24, fractional bits (1.0 = 1<<FRAC_W)
ITER_W, 16, width of iteration limit/counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin job; sampled only in IDLE
abort  in  1  cancel job, return to IDLE
tol  in  DATA_W  unsigned convergence tolerance, sampled at start
max_iter  in  ITER_W  sweep limit, sampled at start; 0 treated as 1
h2f  in  DATA_W  signed h^2*f source term, sampled at start
in_data  in  DATA_W  grid sample, row-major
in_valid  in  1  in_data valid
in_ready  out  1  solver accepts a sample
out_data  out  DATA_W  result sample, row-major
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts a sample
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job end
converged  out  1  last job met tolerance; held until next start
iter_count  out  ITER_W  sweeps completed; held until next start

Behaviour:
- Reset: state IDLE; in_ready, out_valid, busy, done, converged = 0; out_data = 0; iter_count = 0; bank select = 0. Memory contents are undefined.
- States: IDLE -> LOAD -> SWEEP <-> CHECK -> DRAIN -> IDLE.
- IDLE -> LOAD:
  - Taken on start.
  - Latches tol, max_iter (0 becomes 1) and h2f.
  - Clears iter_count, converged, max_diff and the address counter.
- LOAD:
  - in_ready = 1.
  - Each in_valid&in_ready beat writes bank[sel][addr] and increments addr.
  - The beat at addr == DEPTH-1 moves to SWEEP with addr = 0.
- SWEEP: one cell per cycle, addr 0..DEPTH-1.
  - Reads are combinational from bank[sel]; the write goes to bank[~sel].
  - Boundary cell (row 0, row M+1, col 0 or col M+1): copied unchanged; it does not contribute to diff.
  - Interior cell:
    - s = N+S+E+W+h2f, computed at DATA_W+3 bits, sign-extended.
    - new = s >>> 2 (arithmetic shift, floors toward -inf), saturated to the signed DATA_W range.
    - diff = |new - old|, computed at DATA_W+1 bits, saturated to unsigned DATA_W.
    - max_diff <= max(max_diff, diff) in the same cycle. No one-cycle lag is permitted.
  - At addr == DEPTH-1: go to CHECK.
- CHECK (1 cycle):
  - sel <= ~sel; iter_count += 1.
  - If max_diff <= tol: converged = 1, go to DRAIN.
  - Else if iter_count+1 == max_iter: converged = 0, go to DRAIN.
  - Else: max_diff = 0, addr = 0, go to SWEEP.
- Per-iteration latency: DEPTH+1 cycles.
- DRAIN:
  - Streams bank[sel] (the newest result) row-major.
  - out_valid = 1, and out_data is held stable until out_ready.
  - The handshake on the last cell (DEPTH-1) leads to: out_valid = 0, done pulses the next cycle, then IDLE.
- abort: in any non-IDLE state, go to IDLE next cycle.
  - in_ready and out_valid drop; no done pulse.
  - converged = 0; iter_count keeps its current value.
  - abort has priority over all other transitions.
- start outside IDLE is ignored.
- Simultaneous start+abort in IDLE: start wins.
- in_valid outside LOAD is ignored; no write occurs.

Decomposition:
- Package jacobi_pkg holds:
  - state enum;
  - FIX_ONE constant;
  - sat_signed / sat_unsigned functions;
  - is_boundary(addr) helper based on row/col counters. Use separate row/col counters, not div/mod.
- Sub-module jacobi_stencil_pe (combinational):
  - inputs: N, S, E, W, center, h2f, boundary flag;
  - outputs: new, diff.
- The top level owns the FSM, the two banks and the stream handshakes.

Test Plan:
- M=4, all 36 cells = 0x00800000, tol=0, max_iter=10 -> iter_count=1, converged=1, output equals input, done after 36 out beats.
- M=4, row0 = 0x01000000, rest 0, tol=0, max_iter=3 -> converged=0, iter_count=3. A separate max_iter=1 run gives (1,1..4) = 0x00400000 and other interior cells 0.
- All-zero grid, h2f=0x00400000, max_iter=1 -> every interior cell = 0x00100000, boundary cells 0.
- Boundary = 0xFF000000 (-1.0), interior 0, max_iter=1 -> (1,1) = 0xFF800000, (1,2) = 0xFFC00000, (2,2) = 0.
- out_ready toggled pseudo-randomly during DRAIN -> exactly 36 beats in row-major order, no duplicates or drops, and out_data stable while stalled.
- abort asserted mid-SWEEP -> IDLE next cycle, no done; an immediate new start then completes normally. rst_n asserted mid-LOAD returns all outputs to their reset values.
